fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of instructionmemory.
- Owns the program counter and drives the word address into the instruction memory.
- Instruction memory samples the address on the negedge of clk; this block captures the returned word on the following posedge into the IF/ID pipeline register, together with its PC and a valid bit.
- Handles the pipeline stall, branch/jump redirect (flush), PC wrap-around and a fetched-instruction counter.

---
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// captures the returned word into the IF/ID register with its PC and a valid bit.
module fetch_unit #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] ADDR_MASK = 32'(MEM_DEPTH - 1);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [31:0]     inst_d;
    logic [31:0]     ifpc_d;
    logic            valid_d;
    logic [31:0]     count_d;
    logic [AW-1:0]   target_c;

    // Redirect targets are folded into the memory's address range.
    assign target_c  = AW'(redirect_target & ADDR_MASK);
    assign imem_addr = 32'(pc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= AW'(RESET_PC);
            ifid_inst   <= NOP_WORD;
            ifid_pc     <= 32'd0;
            ifid_valid  <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ifid_inst   <= inst_d;
            ifid_pc     <= ifpc_d;
            ifid_valid  <= valid_d;
            fetch_count <= count_d;
        end
    end

    // Next-state: BOOT waits one edge for the memory output; RUN is redirect > stall > advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = ifid_inst;
        ifpc_d  = ifid_pc;
        valid_d = ifid_valid;
        count_d = fetch_count;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redirect_valid) begin
                    pc_d = target_c;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = target_c;
                    inst_d  = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    inst_d  = imem_inst;
                    ifpc_d  = 32'(pc_q);
                    valid_d = 1'b1;
                    count_d = fetch_count + 32'd1;
                    pc_d    = pc_q + AW'(1);
                end
            end
            default: state_d = BOOT;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reference model of the fetch rules checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst = 32'd0;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.MEM_DEPTH(DEPTH), .RESET_PC(32'd0), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: registered read on the falling edge.
    always @(negedge clk) imem_inst <= 32'hA500_0000 | imem_addr;

    // Reference model: what each register must hold after every rising edge.
    int unsigned m_pc, m_ifpc, m_cnt;
    logic [31:0] m_inst;
    bit          m_valid, m_boot, m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_boot = 1'b1; m_inst = NOP; m_ifpc = 0; m_valid = 1'b0; m_cnt = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (m_boot) begin
                m_boot = 1'b0;
                if (redirect_valid) m_pc = redirect_target % DEPTH;
            end else if (redirect_valid) begin
                m_pc = redirect_target % DEPTH;
                m_inst = NOP;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_inst  = 32'hA500_0000 + m_pc;
                m_ifpc  = m_pc;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 1;
                m_pc    = (m_pc + 1) % DEPTH;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the model has seen reset.
    always @(posedge clk) begin
        #2;
        if (m_live) begin
            chk("model_addr",  imem_addr,   32'(m_pc));
            chk("model_inst",  ifid_inst,   m_inst);
            chk("model_pc",    ifid_pc,     32'(m_ifpc));
            chk("model_valid", 32'(ifid_valid), 32'(m_valid));
            chk("model_count", fetch_count, 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic cap(input string name, input logic [31:0] pc, input logic [31:0] cnt);
        chk({name, "_valid"}, 32'(ifid_valid), 32'd1);
        chk({name, "_pc"},    ifid_pc,   pc);
        chk({name, "_inst"},  ifid_inst, 32'hA500_0000 | pc);
        chk({name, "_count"}, fetch_count, cnt);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_addr",  imem_addr, 32'd0);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        rst = 1'b0;
        tick();
        chk("boot_valid", 32'(ifid_valid), 32'd0);
        chk("boot_count", fetch_count, 32'd0);
        tick(); cap("cap0", 32'd0, 32'd1);
        tick(); cap("cap1", 32'd1, 32'd2);
        tick(); cap("cap2", 32'd2, 32'd3);
        tick(); tick();
        chk("pc5_addr", imem_addr, 32'd5);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cap("stall", 32'd4, 32'd5);
            chk("stall_addr", imem_addr, 32'd5);
        end
        stall = 1'b0;
        tick(); cap("unstall", 32'd5, 32'd6);
        tick();
        chk("pc7_addr", imem_addr, 32'd7);

        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();
        chk("redir_valid", 32'(ifid_valid), 32'd0);
        chk("redir_inst",  ifid_inst, 32'd0);
        chk("redir_addr",  imem_addr, 32'h40);
        chk("redir_count", fetch_count, 32'd7);
        redirect_valid = 1'b0;
        tick(); cap("tgt40", 32'h40, 32'd8);

        redirect_valid = 1'b1; stall = 1'b1; redirect_target = 32'h10;
        tick();
        chk("rs_addr",  imem_addr, 32'h10);
        chk("rs_valid", 32'(ifid_valid), 32'd0);
        redirect_valid = 1'b0; stall = 1'b0;
        tick(); cap("tgt10", 32'h10, 32'd9);

        redirect_valid = 1'b1; redirect_target = 32'hFE;
        tick();
        redirect_valid = 1'b0;
        tick(); cap("wrapFE", 32'hFE, 32'd10);
        tick(); cap("wrapFF", 32'hFF, 32'd11);
        tick(); cap("wrap00", 32'h00, 32'd12);
        tick(); cap("wrap01", 32'h01, 32'd13);

        redirect_valid = 1'b1; redirect_target = 32'h1_0003;
        tick();
        chk("fold_addr", imem_addr, 32'd3);
        redirect_valid = 1'b0;
        repeat (6) tick();
        chk("pc9_addr", imem_addr, 32'd9);

        stall = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("rst2_addr",  imem_addr, 32'd0);
        chk("rst2_valid", 32'(ifid_valid), 32'd0);
        chk("rst2_count", fetch_count, 32'd0);
        rst = 1'b0; stall = 1'b0;
        tick();
        chk("boot2_valid", 32'(ifid_valid), 32'd0);
        tick(); cap("cap0b", 32'd0, 32'd1);

        // Redirect arriving during BOOT moves the PC but captures nothing.
        rst = 1'b1;
        tick();
        rst = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h120;
        tick();
        chk("bootredir_addr",  imem_addr, 32'h20);
        chk("bootredir_valid", 32'(ifid_valid), 32'd0);
        redirect_valid = 1'b0;
        tick(); cap("bootredir_cap", 32'h20, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
